// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: expands the cipher key forward to round 10,
// then walks the schedule backwards one round per consumer acknowledge,
// serving round keys 10 down to 0 without storing the expanded schedule.
module inv_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ack,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w)): rotate left one byte, then substitute each byte
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  state_t       state;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p1, p2, p3;
  logic [31:0]  sb_in, t;
  logic [3:0]   rc_idx;
  logic [127:0] fwd_key, bwd_key;

  // One shared S-box word: forward feeds w3, backward feeds the recovered w3 (w3^w2)
  always_comb begin
    w0      = round_key[127:96];
    w1      = round_key[95:64];
    w2      = round_key[63:32];
    w3      = round_key[31:0];
    p3      = w3 ^ w2;
    p2      = w2 ^ w1;
    p1      = w1 ^ w0;
    sb_in   = (state == SERVE) ? p3 : w3;
    rc_idx  = (state == SERVE) ? round_idx : round_idx + 4'd1;
    t       = sub_rot(sb_in) ^ {rcon(rc_idx), 24'h000000};
    fwd_key = {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};
    bwd_key = {w0 ^ t, p1, p2, p3};
  end

  // Control FSM with registered key, index and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            round_key <= key_in;
            round_idx <= 4'd0;
            busy      <= 1'b1;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          round_key <= fwd_key;
          round_idx <= round_idx + 4'd1;
          if (round_idx == LAST - 4'd1) begin
            key_valid <= 1'b1;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (key_ack) begin
            if (round_idx != 4'd0) begin
              round_key <= bwd_key;
              round_idx <= round_idx - 4'd1;
            end else begin
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: FIPS-197 key schedule served in reverse,
// ack patterns, ignored start pulses, async abort and start/ack collision.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         key_ack;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  inv_key_schedule #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .key_ack   (key_ack),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_KEY  = 128'hffeeddccbbaa99887766554433221100;

  vec_t tbl[11];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse start for one edge with key k; returns at the negedge after the start edge
  task automatic start_key(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait (bounded) for key_valid; n = number of further edges waited
  task automatic wait_valid(output int n);
    n = 0;
    while (!key_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!key_valid) begin
      nvec++;
      nfail++;
      $display("FAIL wait_valid: got timeout expected key_valid");
    end
  endtask

  // Serve all keys with key_ack high; optionally pulse start mid-serve with another key
  task automatic serve_all(input string tag, input bit inject);
    for (int i = 0; i < 11; i++) begin
      chk({tag, "_valid"}, 128'(key_valid), 128'(1'b1));
      chk({tag, "_idx"}, 128'(round_idx), 128'(tbl[i].idx));
      chk({tag, "_key"}, round_key, tbl[i].key);
      key_ack = 1'b1;
      start   = inject && (i == 4);
      key_in  = (inject && i == 4) ? ALT_KEY : FIPS_KEY;
      @(negedge clk);
      start   = 1'b0;
    end
    key_ack = 1'b0;
    chk({tag, "_done"}, 128'(done), 128'(1'b1));
    chk({tag, "_valid_off"}, 128'(key_valid), 128'(1'b0));
    chk({tag, "_busy_off"}, 128'(busy), 128'(1'b0));
    chk({tag, "_idx_hold"}, 128'(round_idx), 128'(4'd0));
    chk({tag, "_key_hold"}, round_key, FIPS_KEY);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 128'(done), 128'(1'b0));
  endtask

  initial begin
    int n;
    int e;
    int cyc;
    bit a;
    logic [127:0] held;

    tbl[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    tbl[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    tbl[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    tbl[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    tbl[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    tbl[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    tbl[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    tbl[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[10] = '{4'd0,  FIPS_KEY};

    rst = 1'b1; start = 1'b0; key_ack = 1'b0; key_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_key", round_key, 128'h0);
    chk("rst_idx", 128'(round_idx), 128'h0);
    chk("rst_valid", 128'(key_valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // Latency and full serve with ack held high
    start_key(FIPS_KEY);
    chk("s1_busy", 128'(busy), 128'(1'b1));
    chk("s1_idx0", 128'(round_idx), 128'h0);
    wait_valid(n);
    chk("s1_latency", 128'(n), 128'(10));
    serve_all("s2", 1'b0);

    // Random acknowledges; key must stay put while key_ack is low
    start_key(FIPS_KEY);
    wait_valid(n);
    e = 0; cyc = 0;
    while (e < 11 && cyc < 300) begin
      chk("s3_idx", 128'(round_idx), 128'(tbl[e].idx));
      chk("s3_key", round_key, tbl[e].key);
      a = 1'($urandom_range(0, 1));
      key_ack = a;
      @(negedge clk);
      cyc++;
      if (a) e++;
    end
    key_ack = 1'b0;
    chk("s3_done", 128'(done), 128'(1'b1));
    @(negedge clk);

    // Long hold with key_ack low
    start_key(FIPS_KEY);
    wait_valid(n);
    held = round_key;
    repeat (5) @(negedge clk);
    chk("hold_key", round_key, tbl[0].key);
    chk("hold_idx", 128'(round_idx), 128'(4'd10));

    // Serve with start pulse mid-serve (ignored)
    serve_all("s4b", 1'b1);

    // Start pulse during EXPAND with another key (ignored)
    start_key(FIPS_KEY);
    @(negedge clk);
    key_in = ALT_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(n);
    serve_all("s4a", 1'b0);

    // Asynchronous reset at idx 5 in SERVE
    start_key(FIPS_KEY);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      key_ack = 1'b1;
      @(negedge clk);
    end
    key_ack = 1'b0;
    chk("s5_pre_idx", 128'(round_idx), 128'(4'd5));
    #2 rst = 1'b1;
    #1;
    chk("s5_key", round_key, 128'h0);
    chk("s5_idx", 128'(round_idx), 128'h0);
    chk("s5_valid", 128'(key_valid), 128'h0);
    chk("s5_busy", 128'(busy), 128'h0);
    #1 rst = 1'b0;
    start_key(128'h0);
    wait_valid(n);
    chk("s5_zero_idx10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    key_ack = 1'b1;
    @(negedge clk);
    chk("s5_zero_idx9", 128'(round_idx), 128'(4'd9));
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    key_ack = 1'b0;
    chk("s5_zero_done", 128'(done), 128'(1'b1));
    chk("s5_zero_idx0", round_key, 128'h0);
    @(negedge clk);

    // start and key_ack together in IDLE
    @(negedge clk);
    key_in = FIPS_KEY; start = 1'b1; key_ack = 1'b1;
    @(negedge clk);
    start = 1'b0; key_ack = 1'b0;
    chk("s6_busy", 128'(busy), 128'(1'b1));
    chk("s6_done", 128'(done), 128'(1'b0));
    chk("s6_idx", 128'(round_idx), 128'h0);
    n = 0;
    while (!key_valid && n < 40) begin
      chk("s6_no_done", 128'(done), 128'(1'b0));
      @(negedge clk);
      n++;
    end
    chk("s6_latency", 128'(n), 128'(10));
    chk("s6_key10", round_key, tbl[0].key);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
